// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Single-outstanding instruction memory request/response channel.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory and holds the returned word until IF/ID takes it.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               StallF,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    fetch_unit_if.master       imem,
    output logic [31:0]        InstrF,
    output logic [31:0]        PCF,
    output logic [31:0]        PCPlus4F,
    output logic               ValidF
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_buf;
    logic         r_valid;

    logic [31:0]  w_pc_target;
    logic [31:0]  w_pc_plus4;

    assign w_pc_target = {PCTargetE[31:2], 2'b00};
    assign w_pc_plus4  = r_pc + 32'd4;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other; mixing in = would make the result
    // depend on statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_buf   <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (PCSrcE) begin
            // Redirect wins; the only question is whether a response is
            // still in flight that must be swallowed in KILL.
            r_pc    <= w_pc_target;
            r_valid <= 1'b0;
            unique case (r_state)
                REQ:  r_state <= imem.imem_ready  ? KILL : REQ;
                WAIT: r_state <= imem.imem_rvalid ? REQ  : KILL;
                HOLD: r_state <= REQ;
                KILL: r_state <= imem.imem_rvalid ? REQ  : KILL;
                default: r_state <= REQ;
            endcase
        end else begin
            unique case (r_state)
                REQ: begin
                    if (imem.imem_ready) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        r_buf   <= imem.imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!StallF) begin
                        r_pc    <= w_pc_plus4;
                        r_valid <= 1'b0;
                        r_state <= REQ;
                    end
                end
                KILL: begin
                    if (imem.imem_rvalid) r_state <= REQ;
                end
                default: r_state <= REQ;
            endcase
        end
    end

    assign imem.imem_req  = (r_state == REQ) && !reset;
    assign imem.imem_addr = r_pc;

    assign ValidF   = r_valid;
    assign InstrF   = r_valid ? r_buf : NOP_INSTR;
    assign PCF      = r_pc;
    assign PCPlus4F = w_pc_plus4;

    // A response is only legal while one is outstanding.
    a_rvalid_legal: assert property (
        @(posedge clock) disable iff (reset)
        imem.imem_rvalid |-> (r_state == WAIT || r_state == KILL)
    );

endmodule
